ppi_rw_control: RTL and testbench
=================================

Name: ppi_rw_control

Overview:
- Read/write control logic of the 8255-style PPI; sits directly downstream of data_bus_buffer.
- Samples the host strobes (CS_n, RD_n, WR_n, A[1:0]) and the internal bus DIN produced by the buffer.
- Drives the buffer's direction input control_signal, latches the control word, and issues one-cycle port-write, mode-set and port-C bit-set/reset strobes to the port blocks.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on CS_n/RD_n/WR_n; legal 2..3
- RESET_CW, 8'h9B, control word loaded on reset (all ports input, mode 0)

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RESET  input  1  synchronous, active-high reset
- CS_n  input  1  chip select, active low, asynchronous to CLK
- RD_n  input  1  read strobe, active low, asynchronous
- WR_n  input  1  write strobe, active low, asynchronous
- A  input  2  port/control address (0=A, 1=B, 2=C, 3=control)
- DIN  input  8  internal bus from data_bus_buffer
- control_signal  output  1  to data_bus_buffer; 1 = drive PD from DOUT (read), 0 = PD floating
- rd_sel  output  2  selects the source the port mux places on DOUT
- wr_data  output  8  captured write data
- wr_a, wr_b, wr_c  output  1 each  one-cycle port latch write strobes
- ctrl_word  output  8  current control word
- mode_set  output  1  one-cycle pulse on mode-definition write; ports clear their output latches
- pc_bit_we  output  1  one-cycle port-C bit set/reset strobe
- pc_bit_idx  output  3  bit index for pc_bit_we
- pc_bit_val  output  1  bit value for pc_bit_we

Behaviour:
- Reset values:
  - control_signal=0, rd_sel=0, wr_data=0
  - all strobes 0, ctrl_word=RESET_CW, pc_bit_idx=0, pc_bit_val=0
  - synchronizer flops=1 (inactive), cap_valid=0
- Synchronization:
  - CS_n, RD_n, WR_n each pass through SYNC_STAGES flops.
  - A and DIN are sampled raw; the bus must hold them stable for >= SYNC_STAGES+1 CLK before the write terminates.
- Definitions: wr_act = ~CS_s & ~WR_s; rd_act = ~CS_s & ~RD_s & WR_s.
- Capture: every cycle with wr_act=1, register DIN into cap_d, A into cap_a, and set cap_valid=1.
- Commit:
  - Occurs on the 1->0 transition of wr_act (WR_n rise or CS_n rise, whichever comes first), only if cap_valid=1.
  - Outputs are registered 1 cycle later, so strobes appear SYNC_STAGES+1 edges after the first edge that samples the releasing signal high.
  - cap_valid clears on commit.
- Commit decode:
  - cap_a=0/1/2: wr_a/wr_b/wr_c high one cycle; wr_data=cap_d (wr_data holds until the next commit).
  - cap_a=3, cap_d[7]=1: ctrl_word<=cap_d; mode_set high one cycle.
  - cap_a=3, cap_d[7]=0: pc_bit_we high one cycle with pc_bit_idx=cap_d[3:1] and pc_bit_val=cap_d[0]; ctrl_word unchanged.
- Read path (registered):
  - control_signal = rd_act & (A_s != 3), where A_s is A registered alongside the synchronizer.
  - rd_sel = A_s while rd_act; rd_sel holds its last value when idle.
  - control_signal falls one cycle after rd_act deasserts.
- Simultaneous RD_n and WR_n low: write wins, control_signal=0, capture proceeds normally.
- Back-to-back writes: a new wr_act may begin the cycle after commit; no write is lost if WR_n high time >= SYNC_STAGES+1 CLK.
- RESET mid-write:
  - cap_valid cleared, so the aborted write is never committed.
  - If WR_n is still low after RESET drops, wr_act reasserts and the write commits normally on release.
- RESET mid-read: control_signal=0 the cycle after RESET is sampled.
- Strobes are mutually exclusive; at most one of wr_a/wr_b/wr_c/mode_set/pc_bit_we is high per cycle.

Optional Feature:
- Macro: PPI_CW_READBACK_EN
- Defined: a read with A=3 asserts control_signal and rd_sel=3; the port mux returns ctrl_word.
- Undefined: a read with A=3 leaves control_signal=0 (PD floats) and rd_sel unchanged, matching legacy 8255 behaviour.

Test Plan:
- RESET for 2 cycles, release -> ctrl_word=8'h9B, control_signal=0, all strobes 0.
- Write A=3, DIN=8'h80, WR_n low 5 CLK then high -> mode_set pulses once, 3 edges after WR_n rise (SYNC_STAGES=2); ctrl_word=8'h80.
- Write A=3, DIN=8'h0B -> pc_bit_we pulse, pc_bit_idx=5, pc_bit_val=1, ctrl_word unchanged.
- Write A=1, DIN=8'hA5 ended by CS_n rising while WR_n stays low -> single wr_b pulse, wr_data=8'hA5, no second strobe.
- Read A=2, RD_n low 6 CLK -> control_signal=1 from 3rd edge, rd_sel=2, falls 3 edges after RD_n high. Read A=3 -> control_signal stays 0 (macro undefined) / 1 with rd_sel=3 (defined).
- WR_n low with A=0, DIN=8'h3C, RESET pulsed mid-write then WR_n held 4 more CLK and released -> exactly one wr_a with wr_data=8'h3C. Same with RESET applied through the release -> no strobe.

Source files
------------

// File: rtl/ppi_rw_control.sv
// Read/write control for the 8255-style PPI: strobe synchronization, write capture/commit, read steering.
// Optional PPI_CW_READBACK_EN lets a read at A=3 return the control word.
module ppi_rw_control #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  RESET_CW    = 8'h9B
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CS_n,
    input  logic       RD_n,
    input  logic       WR_n,
    input  logic [1:0] A,
    input  logic [7:0] DIN,
    output logic       control_signal,
    output logic [1:0] rd_sel,
    output logic [7:0] wr_data,
    output logic       wr_a,
    output logic       wr_b,
    output logic       wr_c,
    output logic [7:0] ctrl_word,
    output logic       mode_set,
    output logic       pc_bit_we,
    output logic [2:0] pc_bit_idx,
    output logic       pc_bit_val
);

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;

    localparam logic [AW-1:0] ADDR_A    = 2'd0;
    localparam logic [AW-1:0] ADDR_B    = 2'd1;
    localparam logic [AW-1:0] ADDR_C    = 2'd2;
    localparam logic [AW-1:0] ADDR_CTRL = 2'd3;

    logic [SYNC_STAGES-1:0]         cs_sync;
    logic [SYNC_STAGES-1:0]         rd_sync;
    logic [SYNC_STAGES-1:0]         wr_sync;
    logic [SYNC_STAGES-1:0][AW-1:0] a_pipe;

    logic          cs_s;
    logic          rd_s;
    logic          wr_s;
    logic [AW-1:0] a_s;
    logic          wr_act;
    logic          rd_act;
    logic          rd_ok;
    logic          commit;

    logic [DW-1:0] cap_d;
    logic [AW-1:0] cap_a;
    logic          cap_valid;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign rd_s   = rd_sync[SYNC_STAGES-1];
    assign wr_s   = wr_sync[SYNC_STAGES-1];
    assign a_s    = a_pipe[SYNC_STAGES-1];
    assign wr_act = ~cs_s & ~wr_s;
    assign rd_act = ~cs_s & ~rd_s & wr_s;
    // wr_act can only be low here after having captured, i.e. on its falling edge
    assign commit = cap_valid & ~wr_act;

`ifdef PPI_CW_READBACK_EN
    assign rd_ok = rd_act;
`else
    assign rd_ok = rd_act & (a_s != ADDR_CTRL);
`endif

    // Strobe synchronizers; A is delayed by the same depth so it lines up with rd_act
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cs_sync <= '1;
            rd_sync <= '1;
            wr_sync <= '1;
            a_pipe  <= '0;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], CS_n};
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], RD_n};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], WR_n};
            a_pipe  <= {a_pipe[SYNC_STAGES-2:0], A};
        end
    end

    // Write capture: last sample taken while the write is active wins
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cap_d     <= '0;
            cap_a     <= '0;
            cap_valid <= 1'b0;
        end else if (wr_act) begin
            cap_d     <= DIN;
            cap_a     <= A;
            cap_valid <= 1'b1;
        end else if (commit) begin
            cap_valid <= 1'b0;
        end
    end

    // Commit decode into one-cycle strobes
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_a       <= 1'b0;
            wr_b       <= 1'b0;
            wr_c       <= 1'b0;
            mode_set   <= 1'b0;
            pc_bit_we  <= 1'b0;
            wr_data    <= '0;
            ctrl_word  <= RESET_CW;
            pc_bit_idx <= '0;
            pc_bit_val <= 1'b0;
        end else begin
            wr_a      <= 1'b0;
            wr_b      <= 1'b0;
            wr_c      <= 1'b0;
            mode_set  <= 1'b0;
            pc_bit_we <= 1'b0;
            if (commit) begin
                case (cap_a)
                    ADDR_A: begin
                        wr_a    <= 1'b1;
                        wr_data <= cap_d;
                    end
                    ADDR_B: begin
                        wr_b    <= 1'b1;
                        wr_data <= cap_d;
                    end
                    ADDR_C: begin
                        wr_c    <= 1'b1;
                        wr_data <= cap_d;
                    end
                    default: begin
                        if (cap_d[7]) begin
                            ctrl_word <= cap_d;
                            mode_set  <= 1'b1;
                        end else begin
                            pc_bit_we  <= 1'b1;
                            pc_bit_idx <= cap_d[3:1];
                            pc_bit_val <= cap_d[0];
                        end
                    end
                endcase
            end
        end
    end

    // Read steering; rd_sel holds its last value while idle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            control_signal <= 1'b0;
            rd_sel         <= '0;
        end else begin
            control_signal <= rd_ok;
            if (rd_ok) begin
                rd_sel <= a_s;
            end
        end
    end

endmodule

// File: tb/tb_ppi_rw_control.sv
// Self-checking bench for ppi_rw_control: directed test-plan steps followed by randomized
// reads/writes checked against a transaction-level model of the control logic.
module tb_ppi_rw_control;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1;
`ifdef PPI_CW_READBACK_EN
    localparam bit CW_RB = 1'b1;
`else
    localparam bit CW_RB = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CS_n;
    logic       RD_n;
    logic       WR_n;
    logic [1:0] A;
    logic [7:0] DIN;
    logic       control_signal;
    logic [1:0] rd_sel;
    logic [7:0] wr_data;
    logic       wr_a;
    logic       wr_b;
    logic       wr_c;
    logic [7:0] ctrl_word;
    logic       mode_set;
    logic       pc_bit_we;
    logic [2:0] pc_bit_idx;
    logic       pc_bit_val;

    ppi_rw_control #(.SYNC_STAGES(SYNC), .RESET_CW(8'h9B)) dut (
        .CLK(CLK), .RESET(RESET), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A(A), .DIN(DIN),
        .control_signal(control_signal), .rd_sel(rd_sel), .wr_data(wr_data),
        .wr_a(wr_a), .wr_b(wr_b), .wr_c(wr_c), .ctrl_word(ctrl_word), .mode_set(mode_set),
        .pc_bit_we(pc_bit_we), .pc_bit_idx(pc_bit_idx), .pc_bit_val(pc_bit_val)
    );

    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    logic [7:0] ctrl_m;
    logic [7:0] wr_data_m;
    logic [1:0] rd_sel_m;

    // Strobe observations within the current window
    int         seen_cnt;
    int         seen_kind;
    int         seen_pos;
    logic [2:0] seen_idx;
    logic       seen_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ctrl_m    = 8'h9B;
        wr_data_m = 8'h00;
        rd_sel_m  = 2'd0;
    endtask

    task automatic clear_seen();
        seen_cnt  = 0;
        seen_kind = -1;
        seen_pos  = -1;
        seen_idx  = 3'd0;
        seen_val  = 1'b0;
    endtask

    // One clock; sample on the falling edge and log any strobe with its position
    task automatic tick(input int pos);
        int n;
        @(negedge CLK);
        n = int'(wr_a) + int'(wr_b) + int'(wr_c) + int'(mode_set) + int'(pc_bit_we);
        if (n > 1) check("strobe_onehot", 32'(n), 32'd1);
        if (n > 0) begin
            seen_cnt += n;
            seen_pos  = pos;
            seen_kind = wr_a ? 0 : wr_b ? 1 : wr_c ? 2 : mode_set ? 3 : 4;
            seen_idx  = pc_bit_idx;
            seen_val  = pc_bit_val;
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d, input int low,
                            input bit by_cs, input bit rd_too);
        int exp_kind;
        exp_kind = (a != 2'd3) ? int'(a) : (d[7] ? 3 : 4);
        CS_n = 1'b0; WR_n = 1'b0; RD_n = ~rd_too; A = a; DIN = d;
        clear_seen();
        for (int k = 0; k < low; k++) begin
            tick(0);
            check("wr_no_drive", 32'(control_signal), 32'd0);
        end
        if (by_cs) CS_n = 1'b1;
        else begin
            WR_n = 1'b1;
            RD_n = 1'b1;
        end
        for (int k = 1; k <= 8; k++) begin
            tick(k);
            check("wr_no_drive_rel", 32'(control_signal), 32'd0);
        end
        CS_n = 1'b1; WR_n = 1'b1; RD_n = 1'b1;
        if (a != 2'd3) wr_data_m = d;
        else if (d[7]) ctrl_m = d;
        check("wr_strobe_count", 32'(seen_cnt), 32'd1);
        check("wr_strobe_kind", 32'(seen_kind), 32'(exp_kind));
        check("wr_strobe_pos", 32'(seen_pos), 32'(LAT));
        check("ctrl_word", 32'(ctrl_word), 32'(ctrl_m));
        if (a != 2'd3) check("wr_data", 32'(wr_data), 32'(wr_data_m));
        if (exp_kind == 4) begin
            check("pc_bit_idx", 32'(seen_idx), 32'(d[3:1]));
            check("pc_bit_val", 32'(seen_val), 32'(d[0]));
        end
    endtask

    task automatic do_read(input logic [1:0] a, input int hold);
        bit ok;
        ok = (a != 2'd3) || CW_RB;
        CS_n = 1'b0; RD_n = 1'b0; WR_n = 1'b1; A = a;
        clear_seen();
        for (int k = 1; k <= hold; k++) begin
            tick(k);
            check("rd_drive", 32'(control_signal), 32'(ok && (k >= LAT)));
            if (k >= LAT) check("rd_sel_active", 32'(rd_sel), 32'(ok ? a : rd_sel_m));
        end
        if (ok) rd_sel_m = a;
        RD_n = 1'b1; CS_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick(k);
            check("rd_release", 32'(control_signal), 32'(ok && (k < LAT)));
        end
        check("rd_sel_hold", 32'(rd_sel), 32'(rd_sel_m));
        check("rd_no_strobe", 32'(seen_cnt), 32'd0);
    endtask

    initial begin
        RESET = 1'b1; CS_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1; A = 2'd0; DIN = 8'h00;
        model_reset();
        clear_seen();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        tick(0);
        check("rst_ctrl_word", 32'(ctrl_word), 32'h9B);
        check("rst_control_signal", 32'(control_signal), 32'd0);
        check("rst_rd_sel", 32'(rd_sel), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_strobes", 32'({wr_a, wr_b, wr_c, mode_set, pc_bit_we}), 32'd0);
        check("rst_pc_bit", 32'({pc_bit_idx, pc_bit_val}), 32'd0);

        // Directed test-plan steps
        do_write(2'd3, 8'h80, 5, 1'b0, 1'b0);
        do_write(2'd3, 8'h0B, 5, 1'b0, 1'b0);
        do_write(2'd1, 8'hA5, 5, 1'b1, 1'b0);
        do_read(2'd2, 6);
        do_read(2'd3, 6);
        do_write(2'd2, 8'h5A, 4, 1'b0, 1'b1);

        // RESET mid-write, write continues afterwards and commits once
        CS_n = 1'b0; WR_n = 1'b0; RD_n = 1'b1; A = 2'd0; DIN = 8'h3C;
        clear_seen();
        repeat (3) tick(0);
        RESET = 1'b1;
        repeat (2) tick(0);
        RESET = 1'b0;
        model_reset();
        repeat (4) tick(0);
        WR_n = 1'b1;
        for (int k = 1; k <= 8; k++) tick(k);
        CS_n = 1'b1;
        check("rstw_count", 32'(seen_cnt), 32'd1);
        check("rstw_kind", 32'(seen_kind), 32'd0);
        check("rstw_pos", 32'(seen_pos), 32'(LAT));
        check("rstw_wr_data", 32'(wr_data), 32'h3C);
        wr_data_m = 8'h3C;

        // RESET held through the release: aborted write never commits
        do_write(2'd3, 8'h81, 4, 1'b0, 1'b0);
        CS_n = 1'b0; WR_n = 1'b0; A = 2'd0; DIN = 8'hC3;
        clear_seen();
        repeat (3) tick(0);
        RESET = 1'b1;
        repeat (2) tick(0);
        WR_n = 1'b1;
        repeat (3) tick(0);
        RESET = 1'b0;
        model_reset();
        for (int k = 1; k <= 8; k++) tick(k);
        CS_n = 1'b1;
        check("rstr_no_strobe", 32'(seen_cnt), 32'd0);
        check("rstr_ctrl_word", 32'(ctrl_word), 32'h9B);
        check("rstr_wr_data", 32'(wr_data), 32'h00);

        // RESET mid-read drops control_signal on the next edge
        CS_n = 1'b0; RD_n = 1'b0; A = 2'd1;
        repeat (4) tick(0);
        check("rstrd_active", 32'(control_signal), 32'd1);
        RESET = 1'b1;
        tick(0);
        check("rstrd_drop", 32'(control_signal), 32'd0);
        RESET = 1'b0; RD_n = 1'b1; CS_n = 1'b1;
        model_reset();
        repeat (4) tick(0);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] ra;
            logic [7:0] rd;
            ra = 2'($urandom_range(0, 3));
            rd = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                do_read(ra, int'($urandom_range(3, 6)));
            else
                do_write(ra, rd, int'($urandom_range(3, 6)),
                         $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
